uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_tx_fifo_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 78 +++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and default depth.
package uart_tx_fifo_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 4;
  localparam int BYTE_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with occupancy count; full/empty are decoded from the count.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [BYTE_W-1:0]     i_wr_data,
  input  logic                  i_rd_en,
  output logic [BYTE_W-1:0]     o_rd_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [BYTE_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that drains into a UART transmitter with a one-cycle start strobe.
// Handshake: a byte is handed over when dataReady=1 (one cycle); the transmitter acknowledges by raising busy, then dropping it when done.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   wrData,
  input  logic                wrEn,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic [BYTE_W-1:0]   data,
  output logic                dataReady,
  input  logic                busy,
  output drain_state_t        o_dbg_state
);

  drain_state_t      r_state;
  drain_state_t      w_next_state;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;
  logic [BYTE_W-1:0] r_data;
  logic              r_head_valid;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (wrEn),
    .i_wr_data (wrData),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_head_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      // Head is considered stable one cycle after the FIFO first reports data.
      r_head_valid <= !empty;
      if (w_pop) begin
        r_data <= w_head;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_head_valid && !empty && !busy) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE:     w_next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (busy)  w_next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  assign dataReady   = (r_state == ST_ISSUE);
  assign data        = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   wrData = 8'h00;
  logic         wrEn = 1'b0;
  logic         busy = 1'b0;
  logic         full;
  logic         empty;
  logic [4:0]   count;
  logic [7:0]   data;
  logic         dataReady;
  drain_state_t o_dbg_state;

  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         strobes = 0;
  int         busy_left = 0;
  bit         auto_busy = 1'b0;
  logic       prev_dr = 1'b0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wrData      (wrData),
    .wrEn        (wrEn),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .data        (data),
    .dataReady   (dataReady),
    .busy        (busy),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, sample #1 after the edge, update the model, check.
  task automatic step(input logic we, input logic [7:0] wd);
    logic b_edge;
    int   sz_before;
    wrEn      = we;
    wrData    = wd;
    b_edge    = busy;
    sz_before = exp_q.size();
    @(posedge clk);
    #1;
    if (we && sz_before < DEPTH) exp_q.push_back(wd);
    if (dataReady === 1'b1) begin
      strobes++;
      chk("strobe_not_back_to_back", prev_dr, 1'b0);
      chk("strobe_busy_low_at_pop", b_edge, 1'b0);
      chk("strobe_has_data", sz_before != 0, 1'b1);
      if (sz_before != 0) chk("strobe_data_order", data, exp_q.pop_front());
    end
    prev_dr = dataReady;
    chk("count", count, exp_q.size());
    chk("full", full, exp_q.size() == DEPTH);
    chk("empty", empty, exp_q.size() == 0);
    if (auto_busy) begin
      if (dataReady === 1'b1) busy_left = $urandom_range(2, 8);
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("drain_within_budget", n < budget, 1'b1);
    repeat (3) step(1'b0, 8'h00);
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int n = 0;
    while (dataReady !== 1'b1 && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk(tag, dataReady, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_dataReady", dataReady, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_state", o_dbg_state, ST_IDLE);
    reset = 1'b0;

    // Latency: single byte into an empty FIFO with an idle transmitter
    auto_busy = 1'b1;
    step(1'b1, 8'h41);
    step(1'b0, 8'h00);
    chk("lat_edge_n1_no_strobe", dataReady, 1'b0);
    step(1'b0, 8'h00);
    chk("lat_edge_n2_strobe", dataReady, 1'b1);
    chk("lat_data", data, 8'h41);
    chk("lat_count_zero", count, 0);
    step(1'b0, 8'h00);
    chk("lat_one_cycle", dataReady, 1'b0);
    drain(100);

    // Fill to full with the transmitter busy; 17th push is dropped
    auto_busy = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h30 + 8'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_count16", count, 16);
    step(1'b1, 8'hFF);
    chk("fill_drop_count", count, 16);
    auto_busy = 1'b1;
    busy_left = 0;
    strobes = 0;
    drain(500);
    chk("fill_drained_16", strobes, 16);

    // Simultaneous push and pop at count=5
    auto_busy = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i));
    chk("pp_count5", count, 5);
    busy = 1'b0;
    step(1'b1, 8'hB0);
    chk("pp_popped", dataReady, 1'b1);
    chk("pp_count_stays5", count, 5);
    busy = 1'b1;
    step(1'b0, 8'h00);
    auto_busy = 1'b1;
    busy_left = 2;
    drain(300);

    // 20 pushes with interleaved drains: pointer wrap and order
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'hC0 + i));
      step(1'b0, 8'h00);
    end
    drain(500);

    // Random traffic
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
    drain(3000);

    // Stuck transmitter: busy never rises after ISSUE
    auto_busy = 1'b0;
    busy = 1'b0;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h5A);
    wait_strobe("stuck_first_strobe", 10);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00);
      chk("stuck_state_wait_busy", o_dbg_state, ST_WAIT_BUSY);
      chk("stuck_no_second_strobe", dataReady, 1'b0);
    end
    busy = 1'b1;
    step(1'b0, 8'h00);
    auto_busy = 1'b1;
    busy_left = 1;
    drain(200);

    // Reset while in WAIT_DONE with three bytes stored
    auto_busy = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i));
    busy = 1'b0;
    wait_strobe("rstmid_strobe", 10);
    busy = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("rstmid_state_wait_done", o_dbg_state, ST_WAIT_DONE);
    chk("rstmid_count3", count, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_dataReady", dataReady, 1'b0);
    chk("rstmid_count0", count, 0);
    chk("rstmid_empty", empty, 1'b1);
    chk("rstmid_state_idle", o_dbg_state, ST_IDLE);
    chk("rstmid_data", data, 8'h00);
    exp_q.delete();
    prev_dr = 1'b0;
    busy_left = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    busy = 1'b0;
    strobes = 0;
    repeat (10) step(1'b0, 8'h00);
    chk("rstmid_no_strobes_after", strobes, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
